// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state enum, default mult/div latencies and iteration counter width
package multdiv_pkg;
  localparam int COUNT_W = 6;
  localparam int DEF_MULT_CYCLES = 16;
  localparam int DEF_DIV_CYCLES = 32;
  typedef enum logic [1:0] {IDLE, RUN_MULT, RUN_DIV, DONE} state_t;
endpackage

// File: rtl/multdiv_counter6.sv
// counter6: COUNT_W-bit up counter (clock, reset async, clr sync, en) driving the shared dp_count
module counter6 import multdiv_pkg::*; (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + COUNT_W'(1);
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: mult/div control FSM; latches operands (dp_opA/B), sequences dp_count/dp_sel, captures dp results into data_result/data_exception with data_resultRDY pulse and busy stall; MULTDIV_DIV0_SHORTCUT_EN finishes divide-by-zero without iterating
module multdiv_sequencer import multdiv_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [WIDTH-1:0]   dp_opA,
  output logic [WIDTH-1:0]   dp_opB,
  output logic [COUNT_W-1:0] dp_count,
  output logic               dp_sel,
  input  logic [WIDTH-1:0]   dp_mult_result,
  input  logic [WIDTH-1:0]   dp_div_result,
  input  logic               dp_mult_ovf,
  input  logic               dp_div_ovf,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);
  state_t state, state_nxt;
  logic start, div0, run, cap, res_exc;
  logic [WIDTH-1:0] res_val;
  assign start = ctrl_MULT | ctrl_DIV;
  assign div0 = dp_opB == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    run = state == RUN_MULT || state == RUN_DIV;
`ifdef MULTDIV_DIV0_SHORTCUT_EN
    cap = !start && (state == RUN_MULT ? dp_count == COUNT_W'(MULT_CYCLES)
                                       : state == RUN_DIV && (div0 || dp_count == COUNT_W'(DIV_CYCLES)));
`else
    cap = !start && (state == RUN_MULT ? dp_count == COUNT_W'(MULT_CYCLES)
                                       : state == RUN_DIV && dp_count == COUNT_W'(DIV_CYCLES));
`endif
    res_val = state == RUN_MULT ? dp_mult_result : div0 ? '0 : dp_div_result;
    res_exc = state == RUN_MULT ? dp_mult_ovf : div0 | dp_div_ovf;
    state_nxt = ctrl_MULT ? RUN_MULT : ctrl_DIV ? RUN_DIV : cap ? DONE : state == DONE ? IDLE : state;
    busy = run;
    data_resultRDY = state == DONE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      dp_opA <= '0;
      dp_opB <= '0;
      dp_sel <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
    end else begin
      if (start) begin
        dp_opA <= data_operandA;
        dp_opB <= data_operandB;
        dp_sel <= !ctrl_MULT;
      end
      if (cap) begin
        data_result <= res_val;
        data_exception <= res_exc;
      end
    end
  // counter parks at the target during capture so it never runs past it; cleared outside RUN and on restart
  counter6 u_cnt (
    .clock(clock),
    .reset(reset),
    .en(run && !cap),
    .clr(start || !run),
    .count(dp_count)
  );
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: table-driven, hand-sequenced and random checks of multdiv_sequencer with a behavioural datapath stand-in
module tb_multdiv_sequencer;
  logic clock = 0, reset = 1, ctrl_MULT = 0, ctrl_DIV = 0, mult_ovf = 0, div_ovf = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0, dp_opA, dp_opB, data_result;
  logic [31:0] dp_mult_result, dp_div_result;
  logic [5:0] dp_count;
  logic dp_sel, data_exception, data_resultRDY, busy;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  assign dp_mult_result = dp_opA * dp_opB;
  assign dp_div_result = dp_opB == 0 ? 32'hDEADBEEF : 32'($signed(dp_opA) / $signed(dp_opB));
  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .dp_opA(dp_opA), .dp_opB(dp_opB), .dp_count(dp_count), .dp_sel(dp_sel),
    .dp_mult_result(dp_mult_result), .dp_div_result(dp_div_result),
    .dp_mult_ovf(mult_ovf), .dp_div_ovf(div_ovf),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );
  typedef struct {
    bit m;
    bit both;
    logic [31:0] a;
    logic [31:0] b;
    bit mo;
    bit dov;
    logic [31:0] er;
    bit ee;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [32:0] model(bit m, logic [31:0] a, logic [31:0] b, bit mo, bit dov);
    if (m) return {mo, a * b};
    if (b == 0) return {1'b1, 32'h0};
    return {dov, 32'($signed(a) / $signed(b))};
  endfunction
  function automatic int lat_of(bit m, logic [31:0] b);
`ifdef MULTDIV_DIV0_SHORTCUT_EN
    if (!m && b == 0) return 2;
`endif
    return m ? 18 : 34;
  endfunction
  task automatic do_op(input bit m, input bit both, input logic [31:0] a, input logic [31:0] b,
                       input bit mo, input bit dov, input logic [31:0] er, input bit ee, input string nm);
    int lat, rk, n;
    bit cnt_ok, busy_ok;
    lat = lat_of(m, b);
    rk = 0; n = 0; cnt_ok = 1; busy_ok = 1;
    @(negedge clock);
    data_operandA = a; data_operandB = b; mult_ovf = mo; div_ovf = dov;
    ctrl_MULT = m; ctrl_DIV = !m || both;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clock);
      ctrl_MULT = 0; ctrl_DIV = 0;
      data_operandA = $urandom; data_operandB = $urandom;
      if (k == 1) chk({nm, "_sel"}, dp_sel, !m);
      if (k < lat) cnt_ok &= (dp_count == 6'(k - 1));
      busy_ok &= (busy == (k < lat));
      if (data_resultRDY) begin
        n++;
        if (rk == 0) rk = k;
      end
      if (k == lat) begin
        chk({nm, "_result"}, data_result, er);
        chk({nm, "_exception"}, data_exception, ee);
      end
    end
    chk({nm, "_rdy_cycle"}, rk, lat);
    chk({nm, "_rdy_pulses"}, n, 1);
    chk({nm, "_count_seq"}, cnt_ok, 1);
    chk({nm, "_busy_seq"}, busy_ok, 1);
    chk({nm, "_hold"}, {data_result, data_exception, dp_count}, {er, ee, 6'd0});
    chk({nm, "_operands"}, {dp_opA, dp_opB}, {a, b});
  endtask
  initial begin
    int rk, n;
    tbl[0] = '{1, 0, 32'd7, -32'sd6, 0, 0, -32'sd42, 0};
    tbl[1] = '{0, 0, 32'd100, -32'sd7, 0, 0, -32'sd14, 0};
    tbl[2] = '{0, 0, 32'd5, 32'd0, 0, 0, 32'd0, 1};
    tbl[3] = '{0, 0, 32'd5, 32'd0, 0, 1, 32'd0, 1};
    tbl[4] = '{1, 0, 32'h7FFFFFFF, 32'd2, 1, 0, 32'hFFFFFFFE, 1};
    tbl[5] = '{1, 1, 32'd6, 32'd7, 0, 1, 32'd42, 0};
    tbl[6] = '{0, 0, 32'd100, 32'd7, 0, 1, 32'd14, 1};
    tbl[7] = '{1, 0, 32'd0, 32'd123, 0, 0, 32'd0, 0};
    repeat (2) @(negedge clock);
    chk("reset_state", {dp_count, dp_sel, dp_opA, dp_opB, data_result, data_exception, data_resultRDY, busy}, '0);
    reset = 0;
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].m, tbl[i].both, tbl[i].a, tbl[i].b, tbl[i].mo, tbl[i].dov, tbl[i].er, tbl[i].ee,
            $sformatf("vec%0d", i));
    @(negedge clock);
    data_operandA = 50; data_operandB = 5; ctrl_DIV = 1;
    rk = 0; n = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      ctrl_DIV = 0; ctrl_MULT = (k == 10);
      if (k == 10) begin data_operandA = 3; data_operandB = 4; end
      if (data_resultRDY) begin
        n++;
        if (rk == 0) rk = k;
      end
      if (k == 28) chk("restart_result", data_result, 32'd12);
    end
    chk("restart_rdy_cycle", rk, 28);
    chk("restart_rdy_pulses", n, 1);
    @(negedge clock);
    data_operandA = 100; data_operandB = 7; ctrl_DIV = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      ctrl_DIV = 0;
    end
    chk("midop_busy", {busy, dp_count, dp_sel}, {1'b1, 6'd4, 1'b1});
    reset = 1;
    #1;
    chk("midop_reset", {dp_count, dp_sel, dp_opA, dp_opB, data_result, data_exception, data_resultRDY, busy}, '0);
    repeat (2) @(negedge clock);
    reset = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) n++;
    end
    chk("midop_no_rdy", n, 0);
    do_op(1, 0, 32'd2, 32'd2, 0, 0, 32'd4, 0, "after_reset");
    for (int i = 0; i < 20; i++) begin
      bit m, both, mo, dov;
      logic [31:0] a, b;
      logic [32:0] e;
      m = 1'($urandom_range(0, 1));
      both = m && ($urandom_range(0, 3) == 0);
      a = 32'($urandom_range(0, 2000)) - 32'd1000;
      b = 32'($urandom_range(0, 20)) - 32'd10;
      mo = 1'($urandom_range(0, 1));
      dov = 1'($urandom_range(0, 1));
      e = model(m, a, b, mo, dov);
      do_op(m, both, a, b, mo, dov, e[31:0], e[32], $sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
